uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter and sequencer that shares a single UART transmitter between up to eight byte sources. It sits between the byte producers and the `uart` block's `transmit`/`tx_byte` inputs. It paces transmit pulses with its own frame timer, so the UART never sees a request while busy and `tx_overf` stays low. With tagging enabled, it inserts a channel tag byte whenever the source changes and escapes data bytes that collide with the tag space, so the host can demultiplex the stream.

## Interface
- NREQ, 4, number of requesters, legal range 2..8.
- FRAME_CLKS, 240, clocks between successive `transmit` pulses. Must be at least the UART frame time: 11 bits × 4 ticks × CLOCK_DIVIDE, i.e. 220 at 240 MHz / 12 Mbaud.
- TAG_EN, 1, 1 = insert tag and escape bytes; 0 = raw byte passthrough.

- clk  in  1  clock.
- nRst  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-channel byte available.
- req_byte  in  8*NREQ  per-channel byte; channel i occupies bits [8i+7:8i].
- req_ready  out  NREQ  per-channel accept strobe; a handshake completes when valid & ready are both high.
- transmit  out  1  one-cycle pulse to the UART `transmit` input.
- tx_byte  out  8  byte presented to the UART; valid while `transmit`=1.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  3  channel currently or most recently granted.

## Operation
- States: IDLE, TAG, ESC, DATA, WAIT. Registers:
  - `rr_last`: last granted channel; reset value NREQ-1.
  - `last_chan` plus `last_vld`: channel of the last emitted tag and its valid flag; `last_vld` resets to 0.
  - `data_q`: latched data byte.
  - `next_q`: state to enter after WAIT.
  - `timer`: width clog2(FRAME_CLKS).
- IDLE, grant selection: search req_valid starting at (rr_last+1) mod NREQ, wrapping, and take the first asserted channel c.
- IDLE, grant cycle (when any req_valid is high):
  - req_ready[c]=1 combinationally in this cycle; all other req_ready stay 0.
  - data_q ← req_byte[c]; grant_id ← c; rr_last ← c.
  - Next state:
    - TAG if TAG_EN and (!last_vld or c≠last_chan);
    - otherwise ESC if TAG_EN and byte ≥ 8'hF7;
    - otherwise DATA.
- TAG: transmit=1, tx_byte = 8'hF8 + grant_id. last_chan ← grant_id, last_vld ← 1. next_q ← ESC if data_q ≥ 8'hF7, else DATA. Go to WAIT.
- ESC: transmit=1, tx_byte = 8'hF7. next_q ← DATA. Go to WAIT.
- DATA: transmit=1, tx_byte = data_q. next_q ← IDLE. Go to WAIT.
- Timer: every emit state (TAG/ESC/DATA) loads timer ← FRAME_CLKS-2.
- WAIT: decrement timer; when timer==0, go to next_q.
- Host decode rules: 0xF8–0xFF selects channel (value − 0xF8); 0xF7 means the next byte is literal data; all other bytes are data.
- TAG_EN=0: the TAG and ESC states are never entered; last_vld is unused.
- req_valid dropping after the grant has no effect: the byte is already latched.
- tx_byte holds its last value when transmit=0.

## Timing
- Reset values: transmit 0, tx_byte 8'h00, req_ready 0, busy 0, grant_id 0, state IDLE.
- Grant to first transmit pulse: 1 cycle (grant in IDLE at cycle t, emit at t+1).
- Pulses within one grant sequence (TAG→ESC→DATA) are spaced exactly FRAME_CLKS cycles.
- Back-to-back grants: DATA pulse at t; IDLE at t+FRAME_CLKS, which is also the next grant cycle; next emit at t+FRAME_CLKS+1.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep their valid asserted and are served in round-robin order; no channel waits more than NREQ-1 grants.
- Reset mid-operation (any state): at the next edge the block is in IDLE with last_vld=0, transmit=0, busy=0. Any in-flight byte is dropped without a req_ready re-strobe. The first byte after reset always gets a tag when TAG_EN=1.
- req_ready is never high outside IDLE.

## Test plan
- After reset, ch0 presents 0x41 (TAG_EN=1): req_ready[0] high for 1 cycle; transmit pulses carry 0xF8 at t+1 and 0x41 at t+1+FRAME_CLKS; busy drops at t+1+2·FRAME_CLKS.
- ch0 then presents 0x42: one pulse only, 0x42, with no tag.
- ch0–ch3 all valid continuously after the last grant went to ch0: grant order 1,2,3,0,1…; each byte is preceded by tag 0xF9, 0xFA, 0xFB, 0xF8; pulse spacing never below FRAME_CLKS.
- ch2 presents 0xF9 after a different channel was last tagged: pulses are 0xFA, 0xF7, 0xF9, FRAME_CLKS apart.
- TAG_EN=0, ch1 presents 0xFF then 0x00 back-to-back: pulses 0xFF and 0x00, spaced FRAME_CLKS+1; no tag or escape bytes.
- nRst low for 1 cycle during WAIT after a TAG pulse: no DATA pulse follows; busy=0 on the next cycle; the next ch0 byte is again preceded by 0xF8.

Source files
------------

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmitter between byte sources
// Optional channel tag and escape insertion lets the host demultiplex the stream.
`timescale 1ns/1ps
module uart_tx_arb #(
  parameter int NREQ       = 4,
  parameter int FRAME_CLKS = 240,
  parameter int TAG_EN     = 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_byte,
  output logic [NREQ-1:0]   req_ready,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  output logic              busy,
  output logic [2:0]        grant_id
);

  localparam int TW = $clog2(FRAME_CLKS);

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_ESC, S_DATA, S_WAIT} state_t;

  state_t        state_q, state_d, next_q, next_d;
  logic [2:0]    rr_last_q, rr_last_d, last_chan_q, last_chan_d, grant_q, grant_d;
  logic          last_vld_q, last_vld_d;
  logic [7:0]    data_q, data_d, tx_q, tx_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [7:0]    valid8;
  logic [63:0]   byte64;
  logic [7:0]    sel_byte;
  logic [7:0]    ready8;
  logic [2:0]    sel;
  logic          found;
  logic          emit;
  int            cand;

  assign valid8   = 8'(req_valid);
  assign byte64   = 64'(req_byte);
  assign sel_byte = byte64[{sel, 3'b000} +: 8];

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr_last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && valid8[cand[2:0]]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    rr_last_d   = rr_last_q;
    last_chan_d = last_chan_q;
    last_vld_d  = last_vld_q;
    grant_d     = grant_q;
    data_d      = data_q;
    tx_d        = tx_q;
    timer_d     = timer_q;
    emit        = 1'b0;
    ready8      = 8'h00;
    tx_byte     = tx_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ready8    = 8'h01 << sel;
          data_d    = sel_byte;
          grant_d   = sel;
          rr_last_d = sel;
          if (TAG_EN != 0 && (!last_vld_q || sel != last_chan_q)) state_d = S_TAG;
          else if (TAG_EN != 0 && sel_byte >= 8'hF7)              state_d = S_ESC;
          else                                                    state_d = S_DATA;
        end
      end
      S_TAG: begin
        emit        = 1'b1;
        tx_byte     = 8'hF8 + {5'b00000, grant_q};
        last_chan_d = grant_q;
        last_vld_d  = 1'b1;
        next_d      = (data_q >= 8'hF7) ? S_ESC : S_DATA;
      end
      S_ESC: begin
        emit    = 1'b1;
        tx_byte = 8'hF7;
        next_d  = S_DATA;
      end
      S_DATA: begin
        emit    = 1'b1;
        tx_byte = data_q;
        next_d  = S_IDLE;
      end
      S_WAIT: begin
        if (timer_q == '0) state_d = next_q;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Every emit is followed by a WAIT that spaces pulses FRAME_CLKS apart.
    if (emit) begin
      tx_d    = tx_byte;
      timer_d = TW'(FRAME_CLKS - 2);
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      next_q      <= S_IDLE;
      rr_last_q   <= 3'(NREQ - 1);
      last_chan_q <= '0;
      last_vld_q  <= 1'b0;
      grant_q     <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      rr_last_q   <= rr_last_d;
      last_chan_q <= last_chan_d;
      last_vld_q  <= last_vld_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      timer_q     <= timer_d;
    end
  end

  // Gated by nRst so a reset cycle can neither complete a handshake nor pulse the UART.
  assign req_ready = nRst ? ready8[NREQ-1:0] : '0;
  assign transmit  = emit & nRst;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb (tagged and raw instances)
`timescale 1ns/1ps
module tb_uart_tx_arb;
  localparam int NREQ = 4;
  localparam int F    = 20;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [3:0]  va, vb, ra, rb;
  logic [31:0] ba, bb;
  logic        tx_a, tx_b, busy_a, busy_b;
  logic [7:0]  xa, xb;
  logic [2:0]  ga, gb;

  uart_tx_arb #(.NREQ(NREQ), .FRAME_CLKS(F), .TAG_EN(1)) dut_a (
    .clk(clk), .nRst(nRst), .req_valid(va), .req_byte(ba), .req_ready(ra),
    .transmit(tx_a), .tx_byte(xa), .busy(busy_a), .grant_id(ga));

  uart_tx_arb #(.NREQ(NREQ), .FRAME_CLKS(F), .TAG_EN(0)) dut_b (
    .clk(clk), .nRst(nRst), .req_valid(vb), .req_byte(bb), .req_ready(rb),
    .transmit(tx_b), .tx_byte(xb), .busy(busy_b), .grant_id(gb));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int b; int gg; int gp; } exp_t;
  exp_t pq_a[$], pq_b[$];
  int   gq_a[$], gq_b[$];
  int   lg_a = 0, lg_b = 0, lp_a = 0, lp_b = 0, hs_a = 0, hs_b = 0;

  task automatic pa(input int b, input int gg, input int gp);
    exp_t e; e.b = b; e.gg = gg; e.gp = gp; pq_a.push_back(e);
  endtask
  task automatic pb(input int b, input int gg, input int gp);
    exp_t e; e.b = b; e.gg = gg; e.gp = gp; pq_b.push_back(e);
  endtask

  // Monitors: grants and pulses checked against queued expectations
  always @(negedge clk) if (nRst) begin
    if ((va & ra) != 0) begin
      chk("a_ready_onehot", $countones(ra), 1);
      for (int i = 0; i < 4; i++) if (va[i] && ra[i]) begin
        if (gq_a.size() == 0) chk("a_unexpected_grant", i, -1);
        else chk("a_grant_chan", i, gq_a.pop_front());
      end
      chk("a_ready_only_idle", busy_a, 0);
      lg_a = cyc; hs_a++;
    end
    if (tx_a) begin
      if (pq_a.size() == 0) chk("a_unexpected_pulse", xa, -1);
      else begin
        exp_t e;
        e = pq_a.pop_front();
        chk("a_tx_byte", xa, e.b);
        if (e.gg > 0) chk("a_grant_to_pulse", cyc - lg_a, e.gg);
        if (e.gp > 0) chk("a_pulse_gap", cyc - lp_a, e.gp);
      end
      lp_a = cyc;
    end
    if ((vb & rb) != 0) begin
      for (int i = 0; i < 4; i++) if (vb[i] && rb[i]) begin
        if (gq_b.size() == 0) chk("b_unexpected_grant", i, -1);
        else chk("b_grant_chan", i, gq_b.pop_front());
      end
      lg_b = cyc; hs_b++;
    end
    if (tx_b) begin
      if (pq_b.size() == 0) chk("b_unexpected_pulse", xb, -1);
      else begin
        exp_t e;
        e = pq_b.pop_front();
        chk("b_tx_byte", xb, e.b);
        if (e.gg > 0) chk("b_grant_to_pulse", cyc - lg_b, e.gg);
        if (e.gp > 0) chk("b_pulse_gap", cyc - lp_b, e.gp);
      end
      lp_b = cyc;
    end
  end

  task automatic wait_grants(input bit b, input int n);
    int start, k;
    start = b ? hs_b : hs_a;
    k = 0;
    while (((b ? hs_b : hs_a) - start) < n && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 2000) chk("timeout_grants", (b ? hs_b : hs_a) - start, n);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (!busy_a && !busy_b) break;
      k++;
    end
    if (k >= 2000) chk("timeout_idle", busy_a | busy_b, 0);
  endtask

  initial begin
    va = '0; vb = '0; ba = '0; bb = '0;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    @(negedge clk);
    chk("rst_transmit", tx_a, 0);
    chk("rst_tx_byte", xa, 0);
    chk("rst_req_ready", ra, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_grant_id", ga, 0);
    chk("rst_b_transmit", tx_b, 0);

    // First byte after reset gets tag F8
    gq_a.push_back(0); pa(8'hF8, 1, 0); pa(8'h41, 0, F);
    ba[7:0] = 8'h41; va[0] = 1'b1;
    wait_grants(0, 1);
    va[0] = 1'b0;
    @(negedge clk);
    chk("t1_ready_one_cycle", ra, 0);
    while (cyc < lg_a + 2*F) @(negedge clk);
    chk("t1_busy_before_drop", busy_a, 1);
    @(negedge clk);
    chk("t1_busy_drop", busy_a, 0);

    // Same channel again: no tag
    gq_a.push_back(0); pa(8'h42, 1, 0);
    ba[7:0] = 8'h42; va[0] = 1'b1;
    wait_grants(0, 1);
    va[0] = 1'b0;
    wait_idle();

    // All channels valid: rotation 1,2,3,0 with tags each time
    for (int r = 0; r < 2; r++)
      for (int j = 1; j <= 4; j++) begin
        int c;
        c = j % 4;
        gq_a.push_back(c); pa(8'hF8 + c, 1, 0); pa(8'h10 + c, 0, F);
      end
    ba = 32'h13121110; va = 4'hF;
    wait_grants(0, 8);
    va = '0;
    wait_idle();

    // Tag-space data byte on a new channel: tag, escape, data
    gq_a.push_back(2); pa(8'hFA, 1, 0); pa(8'hF7, 0, F); pa(8'hF9, 0, F);
    ba[23:16] = 8'hF9; va[2] = 1'b1;
    wait_grants(0, 1);
    va = '0;
    wait_idle();

    // Raw passthrough, back-to-back on ch1
    gq_b.push_back(1); gq_b.push_back(1);
    pb(8'hFF, 1, 0); pb(8'h00, 1, F + 1);
    bb[15:8] = 8'hFF; vb[1] = 1'b1;
    wait_grants(1, 1);
    bb[15:8] = 8'h00;
    wait_grants(1, 1);
    vb = '0;
    wait_idle();

    // Reset during WAIT after a tag: data byte dropped
    gq_a.push_back(0); pa(8'hF8, 1, 0);
    ba[7:0] = 8'h55; va[0] = 1'b1;
    wait_grants(0, 1);
    va = '0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 nRst = 1'b0;
    @(posedge clk); #1 nRst = 1'b1;
    @(negedge clk);
    chk("t6_busy_after_reset", busy_a, 0);
    chk("t6_transmit_after_reset", tx_a, 0);
    repeat (3*F) @(negedge clk);
    gq_a.push_back(0); pa(8'hF8, 1, 0); pa(8'h66, 0, F);
    ba[7:0] = 8'h66; va[0] = 1'b1;
    wait_grants(0, 1);
    va = '0;
    wait_idle();
    repeat (5) @(negedge clk);

    chk("a_queues_drained", pq_a.size() + gq_a.size(), 0);
    chk("b_queues_drained", pq_b.size() + gq_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
